bus_arbiter: RTL and testbench

- Shares the single synchronous memory port between the 6502 core and one DMA requester (video fetch, loader).
- Owns the core's RDY stall input.
- Grants DMA in bounded bursts and guarantees the CPU a minimum number of cycles between bursts.
- Returns read data to whichever requester issued the access.

---
 rtl/bus_arbiter_if.sv | 54 +++++
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the signals that connect the 6502 core, the DMA requester and the
// single synchronous memory port to the bus arbiter.
//
//   master modport : the arbiter's view (it drives the memory port, RDY,
//                    grant and the two read-data returns)
//   slave modport  : the view of the core / DMA / memory around the arbiter
//
//   cpu_rw/cpu_ad/cpu_dout     core access request (rw: 1=read, 0=write)
//   cpu_din/cpu_rdy            read data and stall back to the core
//   dma_req/dma_rw/dma_ad/dma_dout  DMA access request
//   dma_gnt/dma_din/dma_valid  grant and read return to the DMA requester
//   mem_ad/mem_we/mem_wdata    memory port command
//   mem_rdata                  memory read data, one cycle after the address
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
   logic        cpu_rw;
   logic [15:0] cpu_ad;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;

   logic        dma_req;
   logic        dma_rw;
   logic [15:0] dma_ad;
   logic [7:0]  dma_dout;
   logic        dma_gnt;
   logic [7:0]  dma_din;
   logic        dma_valid;

   logic [15:0] mem_ad;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   modport master (
      input  cpu_rw, cpu_ad, cpu_dout,
      input  dma_req, dma_rw, dma_ad, dma_dout,
      input  mem_rdata,
      output cpu_din, cpu_rdy,
      output dma_gnt, dma_din, dma_valid,
      output mem_ad, mem_we, mem_wdata
   );

   modport slave (
      output cpu_rw, cpu_ad, cpu_dout,
      output dma_req, dma_rw, dma_ad, dma_dout,
      output mem_rdata,
      input  cpu_din, cpu_rdy,
      input  dma_gnt, dma_din, dma_valid,
      input  mem_ad, mem_we, mem_wdata
   );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one synchronous memory port between the 6502 core and a DMA
// requester. The core is stalled through RDY while DMA owns the port. DMA is
// granted in bursts of at most MAX_BURST accesses, and the core always gets at
// least CPU_MIN cycles after reset or after any DMA tenure.
//
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    bus_arbiter_if.master (core, DMA and memory port signals)
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int unsigned MAX_BURST = 4,  // 1..15
   parameter int unsigned CPU_MIN   = 2   // 1..15
) (
   input  logic          clk,
   input  logic          rst_n,
   bus_arbiter_if.master bus
);
   localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);
   localparam logic [3:0] LP_CPU_MIN   = 4'(CPU_MIN);

   typedef enum logic {
      ST_CPU = 1'b0,
      ST_DMA = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [3:0]  r_slot;
   logic [3:0]  w_slot_next;
   logic [3:0]  w_slot_inc;
   logic [3:0]  r_burst;
   logic [3:0]  w_burst_next;
   logic [3:0]  w_burst_inc;
   logic        r_dma_valid;
   logic        w_dma_valid_next;
   logic        r_last_cpu;
   logic [7:0]  r_hold;

   // The slot count includes the current CPU cycle, so the decision can be
   // taken in the CPU_MIN-th CPU cycle and DMA starts right after it.
   assign w_slot_inc  = (r_slot >= LP_CPU_MIN) ? LP_CPU_MIN : r_slot + 4'd1;
   assign w_burst_inc = r_burst + 4'd1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_CPU;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and port decode; everything here depends on registered state,
   // so a grant decided in cycle t takes effect in cycle t+1.
   always_comb begin
      w_state_next     = r_state;
      w_slot_next      = r_slot;
      w_burst_next     = r_burst;
      w_dma_valid_next = 1'b0;
      bus.mem_ad       = bus.cpu_ad;
      bus.mem_wdata    = bus.cpu_dout;
      bus.mem_we       = 1'b0;
      bus.cpu_rdy      = 1'b1;
      bus.dma_gnt      = 1'b0;

      case (r_state)
         ST_CPU: begin
            bus.mem_we  = !bus.cpu_rw;
            w_slot_next = w_slot_inc;
            if (bus.dma_req && (w_slot_inc >= LP_CPU_MIN)) begin
               w_state_next = ST_DMA;
               w_burst_next = 4'd0;
            end
         end
         ST_DMA: begin
            bus.mem_ad    = bus.dma_ad;
            bus.mem_wdata = bus.dma_dout;
            bus.mem_we    = bus.dma_req & !bus.dma_rw;
            bus.cpu_rdy   = 1'b0;
            bus.dma_gnt   = 1'b1;
            if (bus.dma_req) begin
               w_burst_next     = w_burst_inc;
               w_dma_valid_next = bus.dma_rw;
               if (w_burst_inc == LP_MAX_BURST) begin
                  w_state_next = ST_CPU;
                  w_slot_next  = 4'd0;
               end
            end else begin
               // Idle grant cycle: the requester let go, hand the port back.
               w_state_next = ST_CPU;
               w_slot_next  = 4'd0;
            end
         end
         default: begin
            w_state_next = ST_CPU;
         end
      endcase
   end

   // Counters, read-return tracking and the core's read-data hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot      <= 4'd0;
         r_burst     <= 4'd0;
         r_dma_valid <= 1'b0;
         r_last_cpu  <= 1'b1;
         r_hold      <= 8'h00;
      end else begin
         r_slot      <= w_slot_next;
         r_burst     <= w_burst_next;
         r_dma_valid <= w_dma_valid_next;
         r_last_cpu  <= (r_state == ST_CPU);
         if (r_last_cpu) begin
            r_hold <= bus.mem_rdata;
         end
      end
   end

   // While the core is stalled its D_in must not change, so it sees the value
   // captured from its last owned cycle instead of whatever DMA is reading.
   assign bus.cpu_din   = r_last_cpu ? bus.mem_rdata : r_hold;
   assign bus.dma_din   = bus.mem_rdata;
   assign bus.dma_valid = r_dma_valid;
endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   bus_arbiter_if bus ();

   bus_arbiter #(.MAX_BURST(4), .CPU_MIN(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model written by the DUT; ref_mem is the bench's own expectation.
   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_ad] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_ad];
   end

   int n_total = 0;
   int n_bad   = 0;
   int cyc_n   = 0;

   logic [7:0] dma_q [$];
   logic [7:0] cpu_q [$];
   logic       exp_v;
   logic       prev_dma;
   logic       hold_ok;
   logic [7:0] exp_hold;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic c_rw, input logic [15:0] c_ad, input logic [7:0] c_do,
                        input logic d_req, input logic d_rw, input logic [15:0] d_ad,
                        input logic [7:0] d_do);
      bus.cpu_rw   = c_rw;
      bus.cpu_ad   = c_ad;
      bus.cpu_dout = c_do;
      bus.dma_req  = d_req;
      bus.dma_rw   = d_rw;
      bus.dma_ad   = d_ad;
      bus.dma_dout = d_do;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00);
      dma_q.delete();
      cpu_q.delete();
      exp_v    = 1'b0;
      prev_dma = 1'b0;
      hold_ok  = 1'b0;
      #1;
      chk("rst_cpu_rdy", bus.cpu_rdy, 1'b1);
      chk("rst_dma_gnt", bus.dma_gnt, 1'b0);
      chk("rst_dma_valid", bus.dma_valid, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc_n = 0;
   endtask

   // One bus cycle: drive, check at the falling edge, update the scoreboard.
   task automatic cycle(input logic c_rw, input logic [15:0] c_ad, input logic [7:0] c_do,
                        input logic d_req, input logic d_rw, input logic [15:0] d_ad,
                        input logic [7:0] d_do, input logic exp_gnt);
      logic        exp_we;
      logic [15:0] exp_ad;
      logic [7:0]  exp_wd;
      logic [7:0]  d;
      drive(c_rw, c_ad, c_do, d_req, d_rw, d_ad, d_do);
      @(negedge clk);
      // returns for accesses issued in the previous cycle
      chk("dma_valid", bus.dma_valid, exp_v);
      if (exp_v) begin
         d = dma_q.pop_front();
         if (bus.dma_valid) chk("dma_din", bus.dma_din, d);
      end
      if (cpu_q.size() > 0) begin
         exp_hold = cpu_q.pop_front();
         hold_ok  = 1'b1;
         chk("cpu_din", bus.cpu_din, exp_hold);
      end else if (prev_dma && hold_ok) begin
         chk("cpu_din_hold", bus.cpu_din, exp_hold);
      end
      // ownership and memory command this cycle
      chk("dma_gnt", bus.dma_gnt, exp_gnt);
      chk("cpu_rdy", bus.cpu_rdy, !exp_gnt);
      exp_we = exp_gnt ? (d_req & ~d_rw) : ~c_rw;
      exp_ad = exp_gnt ? d_ad : c_ad;
      exp_wd = exp_gnt ? d_do : c_do;
      chk("mem_we", bus.mem_we, exp_we);
      if (!exp_gnt || d_req) chk("mem_ad", bus.mem_ad, exp_ad);
      if (exp_we) begin
         chk("mem_wdata", bus.mem_wdata, exp_wd);
         ref_mem[exp_ad] = exp_wd;
      end
      exp_v = exp_gnt && d_req && d_rw;
      if (exp_v) dma_q.push_back(ref_mem[d_ad]);
      if (!exp_gnt) begin
         if (c_rw) cpu_q.push_back(ref_mem[c_ad]);
         else hold_ok = 1'b0;
      end
      prev_dma = exp_gnt;
      $display("cyc %0d gnt=%0b rdy=%0b mem_ad=%h we=%0b cpu_din=%h dma_valid=%0b dma_din=%h",
               cyc_n, bus.dma_gnt, bus.cpu_rdy, bus.mem_ad, bus.mem_we, bus.cpu_din,
               bus.dma_valid, bus.dma_din);
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic g;
      logic req;
      int   n;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      preload(16'h0000, 8'hA9);
      preload(16'h0001, 8'h42);
      preload(16'h0002, 8'h69);
      preload(16'h0003, 8'h01);
      preload(16'h0010, 8'h5A);
      preload(16'h0200, 8'h11);
      preload(16'h0201, 8'h22);
      preload(16'h0202, 8'h33);
      preload(16'h0203, 8'h44);
      #1;

      // CPU alone reads a short program; no stalls, no grants
      do_reset();
      for (int k = 0; k < 5; k++)
         cycle(1'b1, 16'(k), 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);

      // dma_req held from reset: CPU 0-1, DMA 2-5, CPU 6-7, DMA 8, idle DMA 9
      do_reset();
      n = 0;
      for (int k = 0; k < 12; k++) begin
         g   = ((k >= 2) && (k <= 5)) || (k == 8) || (k == 9);
         req = (k <= 8);
         cycle(1'b1, 16'h0100 + 16'(k), 8'h00, req, 1'b1, 16'h0200 + 16'(n), 8'h00, g);
         if (g && req) n++;
      end

      // core read right before a burst: D_in held through the stall
      do_reset();
      cycle(1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      cycle(1'b1, 16'h0010, 8'h00, 1'b1, 1'b1, 16'h0200, 8'h00, 1'b0);
      for (int k = 0; k < 4; k++)
         cycle(1'b1, 16'h0011, 8'h00, 1'b1, 1'b1, 16'h0200 + 16'(k), 8'h00, 1'b1);
      cycle(1'b1, 16'h0011, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      cycle(1'b1, 16'h0012, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);

      // DMA write then request drops mid-burst; core reads the written byte
      do_reset();
      cycle(1'b0, 16'h0301, 8'h33, 1'b1, 1'b0, 16'h0300, 8'h7E, 1'b0);
      cycle(1'b1, 16'h0001, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h7E, 1'b0);
      cycle(1'b1, 16'h0001, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h7E, 1'b1);
      cycle(1'b1, 16'h0001, 8'h00, 1'b0, 1'b0, 16'h0300, 8'h7E, 1'b1);
      cycle(1'b1, 16'h0300, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      cycle(1'b1, 16'h0301, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      cycle(1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);

      // asynchronous reset while a DMA read return is in flight
      do_reset();
      cycle(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0201, 8'h00, 1'b0);
      cycle(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0201, 8'h00, 1'b0);
      cycle(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0201, 8'h00, 1'b1);
      drive(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0202, 8'h00);
      #2;
      chk("pre_rst_dma_valid", bus.dma_valid, 1'b1);
      chk("pre_rst_dma_gnt", bus.dma_gnt, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_dma_gnt", bus.dma_gnt, 1'b0);
      chk("async_rst_cpu_rdy", bus.cpu_rdy, 1'b1);
      chk("async_rst_dma_valid", bus.dma_valid, 1'b0);
      do_reset();
      cycle(1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0203, 8'h00, 1'b0);
      cycle(1'b1, 16'h0001, 8'h00, 1'b1, 1'b1, 16'h0203, 8'h00, 1'b0);
      cycle(1'b1, 16'h0002, 8'h00, 1'b1, 1'b1, 16'h0203, 8'h00, 1'b1);
      cycle(1'b1, 16'h0002, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
      cycle(1'b1, 16'h0002, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
      cycle(1'b1, 16'h0003, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
